// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: response codes and the routing-field width helper.
package axi_node_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Matches the node's `log2 macro: smallest w with v < 2**w (so route_w(2) == 2).
  function automatic int unsigned route_w(input int unsigned v);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++)
      if (64'(v) >= (64'd1 << i)) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/axi_bw_allocator_rr_if.sv
// B-channel bundle between the initiator-side decoders, the allocator and the target side.
interface axi_bw_allocator_rr_if
  import axi_node_pkg::*;
#(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ID_IN   = 4,
  parameter int N_TARG_PORT = 3,
  parameter int AXI_ID_OUT  = AXI_ID_IN + int'(route_w(N_TARG_PORT - 1)),
  parameter int AXI_USER_W  = 6
);
  logic [N_INIT_PORT-1:0][AXI_ID_OUT-1:0] bid_i;
  logic [N_INIT_PORT-1:0][1:0]            bresp_i;
  logic [N_INIT_PORT-1:0][AXI_USER_W-1:0] buser_i;
  logic [N_INIT_PORT-1:0]                 bvalid_i;
  logic [N_INIT_PORT-1:0]                 bready_o;
  logic [AXI_ID_IN-1:0]                   bid_o;
  logic [1:0]                             bresp_o;
  logic [AXI_USER_W-1:0]                  buser_o;
  logic                                   bvalid_o;
  logic                                   bready_i;

  modport slave (
    input  bid_i, bresp_i, buser_i, bvalid_i, bready_i,
    output bready_o, bid_o, bresp_o, buser_o, bvalid_o
  );

  modport master (
    output bid_i, bresp_i, buser_i, bvalid_i, bready_i,
    input  bready_o, bid_o, bresp_o, buser_o, bvalid_o
  );
endinterface

// File: rtl/axi_bw_rr_arbiter.sv
// N-way round-robin arbiter; pointer advances past the winner only when en is high.
module axi_bw_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= '0;
    else if (en) ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/axi_bw_allocator_rr.sv
// Per-target-port B-channel allocator: round-robin over initiator ports into one output register.
// Optional AXI_BW_ERR_CNT_EN adds a saturating error-response counter on err_cnt_o.
module axi_bw_allocator_rr
  import axi_node_pkg::*;
#(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ID_IN   = 4,
  parameter int N_TARG_PORT = 3,
  parameter int AXI_ID_OUT  = AXI_ID_IN + int'(route_w(N_TARG_PORT - 1)),
  parameter int AXI_USER_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef AXI_BW_ERR_CNT_EN
  output logic [15:0]          err_cnt_o,
`endif
  axi_bw_allocator_rr_if.slave bus
);

  localparam int IW = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

  logic [N_INIT_PORT-1:0] gnt;
  logic [IW-1:0]          gnt_idx;
  logic                   load;
  logic [AXI_ID_OUT-1:0]  sel_id;
  logic                   unused_route;

  logic                   bvalid_q;
  logic [AXI_ID_IN-1:0]   bid_q;
  logic [1:0]             bresp_q;
  logic [AXI_USER_W-1:0]  buser_q;

  // Accept a new response whenever the slot is empty or being drained this cycle.
  assign load = (|bus.bvalid_i) && (!bvalid_q || bus.bready_i);

  axi_bw_rr_arbiter #(.N(N_INIT_PORT), .IW(IW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.bvalid_i),
    .en      (load),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.bready_o = load ? gnt : '0;

  // Routing bits were consumed by the decoder; only the original ID travels on.
  assign sel_id       = bus.bid_i[gnt_idx];
  assign unused_route = ^sel_id[AXI_ID_OUT-1:AXI_ID_IN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
      buser_q  <= '0;
    end else if (load) begin
      bvalid_q <= 1'b1;
      bid_q    <= sel_id[AXI_ID_IN-1:0];
      bresp_q  <= bus.bresp_i[gnt_idx];
      buser_q  <= bus.buser_i[gnt_idx];
    end else if (bus.bready_i) begin
      bvalid_q <= 1'b0;
    end
  end

  assign bus.bvalid_o = bvalid_q;
  assign bus.bid_o    = bid_q;
  assign bus.bresp_o  = bresp_q;
  assign bus.buser_o  = buser_q;

`ifdef AXI_BW_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // bresp[1] set covers both SLVERR and DECERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_q <= '0;
    else if (bvalid_q && bus.bready_i && bresp_q[1] && (err_cnt_q != 16'hFFFF))
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi_bw_allocator_rr.sv
// Directed self-checking bench for axi_bw_allocator_rr (define AXI_BW_ERR_CNT_EN for counter tests).
module tb_axi_bw_allocator_rr;
  import axi_node_pkg::*;

  localparam int N  = 4;
  localparam int IDI = 4;
  localparam int UW = 6;

  logic gclk;
  logic rst_n;
  int   n_chk, n_fail;

  axi_bw_allocator_rr_if #(.N_INIT_PORT(N), .AXI_ID_IN(IDI), .N_TARG_PORT(3), .AXI_USER_W(UW)) bus ();

`ifdef AXI_BW_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  axi_bw_allocator_rr #(.N_INIT_PORT(N), .AXI_ID_IN(IDI), .N_TARG_PORT(3), .AXI_USER_W(UW)) dut (
    .clk       (gclk),
    .rst_n     (rst_n),
`ifdef AXI_BW_ERR_CNT_EN
    .err_cnt_o (err_cnt),
`endif
    .bus       (bus)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic tick();
    @(posedge gclk); #1;
  endtask

  function automatic logic [3:0] id_of(input int k);
    return 4'(8 + k);
  endfunction

  function automatic logic [5:0] user_of(input int k);
    return 6'(16 + k);
  endfunction

  task automatic set_port(input int k, input logic v, input logic [1:0] resp);
    bus.bvalid_i[k] = v;
    bus.bid_i[k]    = {2'(k), id_of(k)};
    bus.bresp_i[k]  = resp;
    bus.buser_i[k]  = user_of(k);
  endtask

  task automatic do_reset();
    bus.bvalid_i = '0;
    bus.bready_i = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.bvalid_i = '0;
    bus.bid_i    = '0;
    bus.bresp_i  = '0;
    bus.buser_i  = '0;
    bus.bready_i = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    n_chk++; if (bus.bvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid got %b exp 0", bus.bvalid_o); end
    n_chk++; if (bus.bid_o !== 4'h0) begin n_fail++; $display("FAIL reset_bid got %h exp 0", bus.bid_o); end
    n_chk++; if (bus.bready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_bready got %b exp 0000", bus.bready_o); end
`ifdef AXI_BW_ERR_CNT_EN
    n_chk++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_errcnt got %h exp 0", err_cnt); end
`endif
    rst_n = 1'b1;
    tick();
    n_chk++; if (bus.bvalid_o !== 1'b0) begin n_fail++; $display("FAIL idle_bvalid got %b exp 0", bus.bvalid_o); end
  endtask

  task automatic test_single();
    do_reset();
    set_port(2, 1'b1, RESP_OKAY);
    #1;
    n_chk++; if (bus.bready_o !== 4'b0100) begin n_fail++; $display("FAIL single_bready got %b exp 0100", bus.bready_o); end
    n_chk++; if (bus.bvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_pre_bvalid got %b exp 0", bus.bvalid_o); end
    tick();
    set_port(2, 1'b0, RESP_OKAY);
    n_chk++; if (bus.bvalid_o !== 1'b1) begin n_fail++; $display("FAIL single_bvalid got %b exp 1", bus.bvalid_o); end
    n_chk++; if (bus.bid_o !== 4'hA) begin n_fail++; $display("FAIL single_bid got %h exp a", bus.bid_o); end
    n_chk++; if (bus.bresp_o !== 2'b00) begin n_fail++; $display("FAIL single_bresp got %b exp 00", bus.bresp_o); end
    n_chk++; if (bus.buser_o !== user_of(2)) begin n_fail++; $display("FAIL single_buser got %h exp %h", bus.buser_o, user_of(2)); end
    tick();
    n_chk++; if (bus.bvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b exp 0", bus.bvalid_o); end
  endtask

  task automatic test_rr_all();
    logic [3:0] exp_g;
    do_reset();
    for (int k = 0; k < N; k++) set_port(k, 1'b1, RESP_OKAY);
    for (int i = 0; i < 16; i++) begin
      exp_g = 4'b0001 << (i % N);
      #1;
      n_chk++; if (bus.bready_o !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b exp %b", i, bus.bready_o, exp_g); end
      tick();
      n_chk++;
      if (bus.bvalid_o !== 1'b1 || bus.bid_o !== id_of(i % N)) begin
        n_fail++; $display("FAIL rr_out[%0d] got v=%b id=%h exp v=1 id=%h", i, bus.bvalid_o, bus.bid_o, id_of(i % N));
      end
    end
    bus.bvalid_i = '0;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    bus.bready_i = 1'b0;
    set_port(1, 1'b1, RESP_EXOKAY);
    set_port(3, 1'b1, RESP_SLVERR);
    #1;
    n_chk++; if (bus.bready_o !== 4'b0010) begin n_fail++; $display("FAIL stall_first_gnt got %b exp 0010", bus.bready_o); end
    tick();
    set_port(1, 1'b0, RESP_EXOKAY);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (bus.bready_o !== 4'b0000) begin n_fail++; $display("FAIL stall_bready[%0d] got %b exp 0000", i, bus.bready_o); end
      n_chk++;
      if (bus.bvalid_o !== 1'b1 || bus.bid_o !== id_of(1) || bus.bresp_o !== RESP_EXOKAY || bus.buser_o !== user_of(1)) begin
        n_fail++; $display("FAIL stall_hold[%0d] got v=%b id=%h r=%b u=%h exp v=1 id=%h r=01 u=%h",
                           i, bus.bvalid_o, bus.bid_o, bus.bresp_o, bus.buser_o, id_of(1), user_of(1));
      end
      tick();
    end
    bus.bready_i = 1'b1;
    #1;
    n_chk++; if (bus.bready_o !== 4'b1000) begin n_fail++; $display("FAIL stall_release_gnt got %b exp 1000", bus.bready_o); end
    tick();
    set_port(3, 1'b0, RESP_SLVERR);
    n_chk++;
    if (bus.bvalid_o !== 1'b1 || bus.bid_o !== id_of(3) || bus.bresp_o !== RESP_SLVERR) begin
      n_fail++; $display("FAIL stall_p3_out got v=%b id=%h r=%b exp v=1 id=%h r=10", bus.bvalid_o, bus.bid_o, bus.bresp_o, id_of(3));
    end
    tick();
    n_chk++; if (bus.bvalid_o !== 1'b0) begin n_fail++; $display("FAIL stall_drain got %b exp 0", bus.bvalid_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_port(2, 1'b1, RESP_OKAY);
    tick();
    set_port(2, 1'b0, RESP_OKAY);
    tick();
    // pointer now 3, only port 0 requesting
    set_port(0, 1'b1, RESP_OKAY);
    #1;
    n_chk++; if (bus.bready_o !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt0 got %b exp 0001", bus.bready_o); end
    tick();
    n_chk++; if (bus.bid_o !== id_of(0)) begin n_fail++; $display("FAIL wrap_out0 got %h exp %h", bus.bid_o, id_of(0)); end
    set_port(1, 1'b1, RESP_OKAY);
    #1;
    n_chk++; if (bus.bready_o !== 4'b0010) begin n_fail++; $display("FAIL wrap_ptr1 got %b exp 0010", bus.bready_o); end
    tick();
    bus.bvalid_i = '0;
    tick();
  endtask

`ifdef AXI_BW_ERR_CNT_EN
  task automatic send_one(input logic [1:0] resp);
    set_port(0, 1'b1, resp);
    tick();
    set_port(0, 1'b0, resp);
  endtask

  task automatic test_err_cnt();
    do_reset();
    send_one(RESP_SLVERR);
    send_one(RESP_DECERR);
    send_one(RESP_OKAY);
    tick();
    n_chk++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL errcnt_count got %0d exp 2", err_cnt); end
    force dut.err_cnt_q = 16'hFFFF;
    #1;
    release dut.err_cnt_q;
    tick();
    n_chk++; if (err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL errcnt_forced got %h exp ffff", err_cnt); end
    send_one(RESP_SLVERR);
    tick();
    n_chk++; if (err_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL errcnt_sat got %h exp ffff", err_cnt); end
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    test_reset();
    test_single();
    test_rr_all();
    test_stall();
    test_wrap();
`ifdef AXI_BW_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
